// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Optional macro SEQ_CHUNK_ADDER_OVF_EN adds a signed-overflow output (ovf).
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_ready/out_valid depend only on state.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     chunk_sum;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  always_comb begin
    a_chunk   = a_q[cnt_q*CHUNK +: CHUNK];
    b_chunk   = b_q[cnt_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction as a + ~b + ~cin: final carry 1 means no borrow.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        if (cnt_q == LAST_CNT) begin
          cout_d  = chunk_sum[CHUNK];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          // Carry into the MSB recovered as r ^ a ^ b at that bit.
          ovf_d   = chunk_sum[CHUNK] ^ chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
`endif
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: vector table + scoreboard on a CHUNK=8 instance, plus a CHUNK=32 instance.
module tb_seq_chunk_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, sum;
  logic             cin = 1'b0, sub = 1'b0, cout;
  logic [1:0]       dbg_state;

  logic             in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [WIDTH-1:0] a2 = '0, b2 = '0, sum2;
  logic             cout2;
  logic [1:0]       dbg_state2;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic ovf, ovf2;
`endif

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .dbg_state(dbg_state)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
    .dbg_state(dbg_state2)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WIDTH+1:0] exp_q[$];   // {ovf, cout, sum}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    logic [WIDTH-1:0] ye;
    logic [WIDTH:0]   r;
    logic             o;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, (s ? ~ci : ci)};
    o  = (x[WIDTH-1] == ye[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return {o, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic ci, input logic s, input logic [WIDTH+1:0] exp);
    int wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom(); b = $urandom();
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic receive(input int hold);
    int edges = 1;   // the accepting edge counts as the first
    logic [WIDTH+1:0] e;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (!out_valid) check("in_ready_run", 64'(in_ready), 64'd0);
    end
    check("latency_edges", 64'(edges), 64'(NCHUNK + 1));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
    check("cout", 64'(cout), 64'(e[WIDTH]));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check("ovf", 64'(ovf), 64'(e[WIDTH+1]));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = $urandom_range(0, 1);
      a = $urandom(); b = $urandom();
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_sum", 64'({cout, sum}), 64'(e[WIDTH:0]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    int               edges;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[8] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};

    // reset state, sampled while rst is still asserted
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           {vecs[i].exp_ovf, vecs[i].exp_cout, vecs[i].exp_sum});
      receive((i == 3) ? 10 : 0);
    end

    // reset during the second RUN cycle discards the operation
    send(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, model(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    check("midrun_rst_sum", 64'(sum), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h23456789});
    receive(2);

    // random traffic against the reference model
    for (int i = 0; i < 12; i++) begin
      ra = $urandom(); rb = $urandom();
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      receive($urandom_range(0, 3));
    end

    // single-chunk instance
    a2 = 32'h80000000; b2 = 32'h80000000; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    edges = 1;
    while (!out_valid2 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("wide_latency_edges", 64'(edges), 64'd2);
    check("wide_sum", 64'(sum2), 64'd0);
    check("wide_cout", 64'(cout2), 64'd1);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check("wide_ovf", 64'(ovf2), 64'd1);
`endif
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("wide_post_hs_in_ready", 64'(in_ready2), 64'd1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
